// File: rtl/palette_lut.sv
// palette_lut: programmable colour look-up table for the VGA pixel path.
// An IDX_W-bit index is mapped to {red, green, blue} (CH_W bits each) through a
// writable table, with exactly two registered stages of latency. After reset the
// table self-loads the 16-entry intro palette, one entry per clock, with busy high.
// Optional fade engine: define PALETTE_FADE_EN to add fade_start/fade_dir/fade_done
// and scale every output pixel by a ramped brightness level.
module palette_lut #(
    parameter int IDX_W = 4,
    parameter int CH_W  = 4
`ifdef PALETTE_FADE_EN
    ,
    parameter int FADE_DIV = 4
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_valid_i,
    input  logic [IDX_W-1:0]    index,
    output logic                pix_valid_o,
    output logic [CH_W-1:0]     red,
    output logic [CH_W-1:0]     green,
    output logic [CH_W-1:0]     blue,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [3*CH_W-1:0]   wr_data,
    output logic                busy
`ifdef PALETTE_FADE_EN
    ,
    input  logic                fade_start,
    input  logic                fade_dir,
    output logic                fade_done
`endif
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int RGB_W = 3 * CH_W;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    // A 4-bit palette nibble left-aligned into a CH_W-bit channel, low bits zero.
    function automatic logic [CH_W-1:0] nib_to_ch(input logic [3:0] n);
        logic [CH_W-1:0] c;
        c = '0;
        c[CH_W-1 -: 4] = n;
        return c;
    endfunction

    // Intro palette; entries beyond 15 load as black.
    function automatic logic [RGB_W-1:0] default_entry(input int unsigned k);
        logic [11:0] n;
        case (k)
            0:       n = 12'hCCC;
            1:       n = 12'h000;
            2:       n = 12'h555;
            3:       n = 12'h333;
            4:       n = 12'h999;
            5:       n = 12'h222;
            6:       n = 12'h811;
            7:       n = 12'hBBB;
            8:       n = 12'h400;
            9:       n = 12'h888;
            10:      n = 12'hEEE;
            11:      n = 12'h444;
            12:      n = 12'hAAA;
            13:      n = 12'h666;
            14:      n = 12'h111;
            default: n = 12'h000;
        endcase
        return {nib_to_ch(n[11:8]), nib_to_ch(n[7:4]), nib_to_ch(n[3:0])};
    endfunction

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;

    logic               tbl_we;
    logic [IDX_W-1:0]   tbl_addr;
    logic [RGB_W-1:0]   tbl_data;

    logic [RGB_W-1:0]   pal_q [DEPTH];
    logic [RGB_W-1:0]   pal_d [DEPTH];

    logic               v1_q, v1_d;
    logic [RGB_W-1:0]   c1_q, c1_d;
    logic               v2_q, v2_d;
    logic [RGB_W-1:0]   c2_q, c2_d;
    logic [RGB_W-1:0]   scaled;

    // Load-sequencer state register; reset from any state restarts at entry 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Load-sequencer next state: one default entry per clock, then RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + IDX_W'(1);
            if (cnt_q == LAST_IDX) begin
                state_d = ST_RUN;
            end
        end
    end

    // Load-sequencer outputs: the table write port is owned by the loader while busy.
    always_comb begin
        busy     = (state_q == ST_INIT);
        tbl_we   = wr_en;
        tbl_addr = wr_addr;
        tbl_data = wr_data;
        if (state_q == ST_INIT) begin
            tbl_we   = 1'b1;
            tbl_addr = cnt_q;
            tbl_data = default_entry(32'(cnt_q));
        end
    end

    // Table next value; lookups in the write cycle still see the old entry.
    always_comb begin
        pal_d = pal_q;
        if (tbl_we) begin
            pal_d[tbl_addr] = tbl_data;
        end
    end

    // Table storage; contents are rebuilt by the load sweep, so no reset.
    always_ff @(posedge clk) begin
        pal_q <= pal_d;
    end

    // Stage 1: read the table; lookups issued while loading are dropped.
    always_comb begin
        v1_d = pix_valid_i & ~busy;
        c1_d = c1_q;
        if (v1_d) begin
            c1_d = pal_q[index];
        end
    end

    // Stage 2: register the (optionally scaled) colour; hold when no pixel.
    always_comb begin
        v2_d = v1_q;
        c2_d = c2_q;
        if (v1_q) begin
            c2_d = scaled;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0;
            c1_q <= '0;
            v2_q <= 1'b0;
            c2_q <= '0;
        end else begin
            v1_q <= v1_d;
            c1_q <= c1_d;
            v2_q <= v2_d;
            c2_q <= c2_d;
        end
    end

    assign pix_valid_o = v2_q;
    assign {red, green, blue} = c2_q;

`ifdef PALETTE_FADE_EN
    localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV - 1);
    localparam logic [CH_W:0]    FULL     = {1'b1, {CH_W{1'b0}}};

    typedef enum logic {FD_IDLE, FD_RAMP} fstate_t;

    fstate_t            fstate_q, fstate_d;
    logic               dir_q, dir_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CH_W:0]      level_q, level_d;
    logic               done_q, done_d;

    // (c * L) >> CH_W, truncating; L = 2**CH_W passes c through unchanged.
    function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c,
                                                 input logic [CH_W:0]   l);
        logic [2*CH_W:0] p;
        p = (2*CH_W+1)'(c) * (2*CH_W+1)'(l);
        return CH_W'(p >> CH_W);
    endfunction

    // Fade state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fstate_q <= FD_IDLE;
            dir_q    <= 1'b1;
            div_q    <= '0;
            level_q  <= FULL;
            done_q   <= 1'b0;
        end else begin
            fstate_q <= fstate_d;
            dir_q    <= dir_d;
            div_q    <= div_d;
            level_q  <= level_d;
            done_q   <= done_d;
        end
    end

    // Fade next state: restartable ramp, one level step every FADE_DIV clocks.
    always_comb begin
        fstate_d = fstate_q;
        dir_d    = dir_q;
        div_d    = div_q;
        level_d  = level_q;
        done_d   = 1'b0;
        if (fade_start) begin
            dir_d = fade_dir;
            div_d = '0;
            if (level_q == (fade_dir ? FULL : '0)) begin
                fstate_d = FD_IDLE;
                done_d   = 1'b1;
            end else begin
                fstate_d = FD_RAMP;
            end
        end else if (fstate_q == FD_RAMP) begin
            if (div_q == DIV_LAST) begin
                div_d   = '0;
                level_d = dir_q ? level_q + (CH_W+1)'(1) : level_q - (CH_W+1)'(1);
                if (level_d == (dir_q ? FULL : '0)) begin
                    fstate_d = FD_IDLE;
                    done_d   = 1'b1;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // Fade outputs: one level value scales all three channels of a pixel.
    always_comb begin
        fade_done = done_q;
        scaled    = {scale_ch(c1_q[3*CH_W-1 -: CH_W], level_q),
                     scale_ch(c1_q[2*CH_W-1 -: CH_W], level_q),
                     scale_ch(c1_q[CH_W-1 -: CH_W],   level_q)};
    end
`else
    // Without the fade engine stage 2 is a plain register.
    always_comb begin
        scaled = c1_q;
    end
`endif

endmodule

// File: tb/tb_palette_lut.sv
// Self-checking bench for palette_lut (default build, IDX_W=4, CH_W=4).
module tb_palette_lut;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid_i = 1'b0;
    logic [3:0]  index = '0;
    logic        pix_valid_o;
    logic [3:0]  red, green, blue;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        busy;
    logic [11:0] rgb;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Intro palette as listed for the block.
    logic [11:0] DEF [16] = '{12'hCCC, 12'h000, 12'h555, 12'h333,
                              12'h999, 12'h222, 12'h811, 12'hBBB,
                              12'h400, 12'h888, 12'hEEE, 12'h444,
                              12'hAAA, 12'h666, 12'h111, 12'h000};

    // Reference model state: table contents, remaining busy clocks, two-deep pipe.
    logic [11:0] ref_tbl [16];
    int          busy_left = 0;
    logic        m_v1 = 1'b0, m_v2 = 1'b0;
    logic [11:0] m_c1 = '0, m_c2 = '0;

    palette_lut #(.IDX_W(4), .CH_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_valid_i (pix_valid_i),
        .index       (index),
        .pix_valid_o (pix_valid_o),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy)
    );

    assign rgb = {red, green, blue};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs seen at this edge, then check outputs.
    task automatic tick();
        logic busy_now;
        @(posedge clk);
        if (reset) begin
            busy_left = 16;
            m_v1 = 1'b0;
            m_v2 = 1'b0;
            m_c1 = '0;
            m_c2 = '0;
            ref_tbl = DEF;
        end else begin
            busy_now = (busy_left > 0);
            m_v2 = m_v1;
            if (m_v1) m_c2 = m_c1;
            m_v1 = pix_valid_i && !busy_now;
            if (m_v1) m_c1 = ref_tbl[index];
            if (wr_en && !busy_now) ref_tbl[wr_addr] = wr_data;
            if (busy_now) busy_left--;
        end
        #1;
        check_eq("busy", 32'(busy), (busy_left > 0) ? 32'd1 : 32'd0);
        check_eq("valid_o", 32'(pix_valid_o), 32'(m_v2));
        check_eq("rgb", 32'(rgb), 32'(m_c2));
    endtask

    initial begin
        int n;

        // Reset state, load sweep length, writes and lookups ignored while loading.
        reset = 1'b1;
        pix_valid_i = 1'b1;
        index = 4'd5;
        tick();
        check_eq("reset_valid_o", 32'(pix_valid_o), 32'd0);
        check_eq("reset_rgb", 32'(rgb), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        wr_en = 1'b1;
        wr_addr = 4'd3;
        wr_data = 12'hFFF;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check_eq("busy_len", 32'(n), 32'd16);
        wr_en = 1'b0;
        pix_valid_i = 1'b1;
        index = 4'd0;
        tick();
        index = 4'd3;
        tick();
        pix_valid_i = 1'b0;
        check_eq("idx0_rgb", 32'(rgb), 32'hCCC);
        check_eq("idx0_valid", 32'(pix_valid_o), 32'd1);
        tick();
        check_eq("busy_write_ignored", 32'(rgb), 32'h333);

        // Back-to-back stream of every entry.
        for (int i = 0; i < 16; i++) begin
            pix_valid_i = 1'b1;
            index = 4'(i);
            tick();
            if (i >= 1) check_eq("stream", 32'(rgb), 32'(DEF[i-1]));
        end
        pix_valid_i = 1'b0;
        tick();
        check_eq("stream_last", 32'(rgb), 32'(DEF[15]));
        tick();
        check_eq("hold_valid", 32'(pix_valid_o), 32'd0);
        check_eq("hold_rgb", 32'(rgb), 32'(DEF[15]));

        // Write and lookup of the same entry in one cycle: old data, then new.
        pix_valid_i = 1'b1;
        index = 4'd6;
        wr_en = 1'b1;
        wr_addr = 4'd6;
        wr_data = 12'hF0A;
        tick();
        wr_en = 1'b0;
        tick();
        pix_valid_i = 1'b0;
        check_eq("rbw_old", 32'(rgb), 32'h811);
        tick();
        check_eq("rbw_new", 32'(rgb), 32'hF0A);

        // Reset in the middle of the load sweep restarts it from entry 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check_eq("busy_len_restart", 32'(n), 32'd16);
        pix_valid_i = 1'b1;
        index = 4'd0;
        tick();
        index = 4'd6;
        tick();
        pix_valid_i = 1'b0;
        check_eq("restart_idx0", 32'(rgb), 32'hCCC);
        tick();
        check_eq("restart_idx6", 32'(rgb), 32'h811);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            pix_valid_i = ($urandom_range(0, 3) != 0);
            index       = 4'($urandom);
            wr_en       = ($urandom_range(0, 3) == 0);
            wr_addr     = 4'($urandom);
            wr_data     = 12'($urandom);
            tick();
        end
        reset = 1'b0;
        pix_valid_i = 1'b0;
        wr_en = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
